// File: rtl/global_buffer_param.sv
// Global buffer shared parameters and types for the GLB <-> CGRA stream path.
package global_buffer_param;

  localparam int CGRA_DATA_WIDTH = 16;

  // One stream beat: payload word plus the control bit that travels with it.
  typedef struct packed {
    logic                       ctrl;
    logic [CGRA_DATA_WIDTH-1:0] data;
  } strm_word_t;

  // Occupancy-derived control state of a stream FIFO.
  typedef enum logic [1:0] {
    STRM_EMPTY   = 2'd0,
    STRM_PARTIAL = 2'd1,
    STRM_FULL    = 2'd2
  } strm_state_e;

  // Classify an occupancy value against the FIFO depth.
  function automatic strm_state_e strm_state(input int cnt, input int depth);
    if (cnt == 0) begin
      return STRM_EMPTY;
    end
    if (cnt >= depth) begin
      return STRM_FULL;
    end
    return STRM_PARTIAL;
  endfunction

endpackage

// File: rtl/glb_strm_fifo_mem.sv
// Register-array storage for the CGRA stream FIFO: one write port,
// asynchronous read port. DEPTH need not be a power of two.
module glb_strm_fifo_mem #(
  parameter int DEPTH      = 4,
  parameter int WIDTH      = 17,
  parameter int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [WIDTH-1:0]      wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [WIDTH-1:0]      rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write the incoming beat into the addressed slot.
  // NOTE: storage has no reset; validity is tracked by the pointers and count,
  // so clearing the array would only cost flops and reset fan-out.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/glb_cgra_strm_fifo.sv
// Elastic ready/valid buffer between a GLB tile stream port and a CGRA
// io16/io1 input. in_rdy is fully registered, so the CGRA back-pressure path
// never reaches the GLB combinationally. Supports group flush and output stall.
// DEPTH must be at least 2 for full single-beat throughput.
module glb_cgra_strm_fifo
  import global_buffer_param::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = CGRA_DATA_WIDTH,
  parameter int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  stall,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_ctrl,
  input  logic                  in_vld,
  output logic                  in_rdy,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_ctrl,
  output logic                  out_vld,
  input  logic                  out_rdy,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  overflow_err
);

  localparam int                   PTR_WIDTH = $clog2(DEPTH);
  localparam logic [PTR_WIDTH-1:0] PTR_LAST  = PTR_WIDTH'(DEPTH - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

  // Pointers run 0..DEPTH-1 and wrap explicitly, so any DEPTH works.
  function automatic logic [PTR_WIDTH-1:0] ptr_inc(input logic [PTR_WIDTH-1:0] ptr);
    return (ptr == PTR_LAST) ? '0 : ptr + PTR_WIDTH'(1);
  endfunction

  logic [PTR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  strm_state_e          state_q, state_d;
  logic                 in_rdy_q, in_rdy_d;
  logic                 out_vld_q, out_vld_d;
  logic                 overflow_err_q, overflow_err_d;

  logic                 push;
  logic                 pop;
  logic                 mem_we;
  logic [DATA_WIDTH:0]  rd_word;

  // Handshakes use only registered ready/valid.
  assign push   = in_vld && in_rdy_q;
  assign pop    = out_vld_q && out_rdy;
  assign mem_we = push && !flush;

  glb_strm_fifo_mem #(
    .DEPTH      (DEPTH),
    .WIDTH      (DATA_WIDTH + 1),
    .ADDR_WIDTH (PTR_WIDTH)
  ) u_mem (
    .clk     (clk),
    .wr_en   (mem_we),
    .wr_addr (wr_ptr_q),
    .wr_data ({in_ctrl, in_data}),
    .rd_addr (rd_ptr_q),
    .rd_data (rd_word)
  );

  // Next-state for pointers, occupancy, control state and registered handshake outputs.
  // NOTE: every variable gets a default at the top of the block, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cnt_d          = cnt_q;
    overflow_err_d = overflow_err_q;

    // in_rdy blocks this; the flag exists to expose a broken handshake.
    if (push && (state_q == STRM_FULL)) begin
      overflow_err_d = 1'b1;
    end

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) begin
        wr_ptr_d = ptr_inc(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
    end

    state_d   = strm_state(32'(cnt_d), DEPTH);
    in_rdy_d  = (state_d != STRM_FULL);
    out_vld_d = (state_d != STRM_EMPTY) && !stall;
  end

  // Control FSM with registered outputs; reset dominates flush.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      state_q        <= STRM_EMPTY;
      in_rdy_q       <= 1'b0;
      out_vld_q      <= 1'b0;
      overflow_err_q <= 1'b0;
    end else begin
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      state_q        <= state_d;
      in_rdy_q       <= in_rdy_d;
      out_vld_q      <= out_vld_d;
      overflow_err_q <= overflow_err_d;
    end
  end

  // Head word is forced to zero whenever nothing is stored.
  assign out_data     = (state_q != STRM_EMPTY) ? rd_word[DATA_WIDTH-1:0] : '0;
  assign out_ctrl     = (state_q != STRM_EMPTY) ? rd_word[DATA_WIDTH]     : 1'b0;
  assign out_vld      = out_vld_q;
  assign in_rdy       = in_rdy_q;
  assign count        = cnt_q;
  assign overflow_err = overflow_err_q;

endmodule

// File: doc/glb_cgra_strm_fifo.md
# glb_cgra_strm_fifo

Elastic ready/valid buffer for one CGRA stream channel. It sits between a GLB tile stream port (strm_data_g2f / strm_ctrl_g2f / vld / rdy) and the matching CGRA io16/io1 input. It decouples GLB bank-read timing from CGRA back-pressure and breaks the combinational ready path. It also supports group flush and stall. One instance is placed per tile per CGRA_PER_GLB lane.

## Interface
Parameters:
- DEPTH, 4: number of entries, ≥2; non-power-of-two allowed.
- DATA_WIDTH, CGRA_DATA_WIDTH (16): payload width.
- CNT_WIDTH, $clog2(DEPTH+1): occupancy width.

Ports (one clock; reset is synchronous and active-high; named clk and reset):
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- flush  in  1  synchronous clear, driven from strm_data_flush_g2f of the owning group
- stall  in  1  freezes the output side
- in_data  in  DATA_WIDTH  word from GLB
- in_ctrl  in  1  control bit travelling with the word
- in_vld  in  1  upstream valid
- in_rdy  out  1  space available; registered
- out_data  out  DATA_WIDTH  head word to CGRA
- out_ctrl  out  1  head control bit
- out_vld  out  1  head valid
- out_rdy  in  1  CGRA ready
- count  out  CNT_WIDTH  current occupancy
- overflow_err  out  1  sticky; set on an internal push-while-full (must never fire)

## Operation
- Push when in_vld && in_rdy; the entry {in_ctrl, in_data} is written at wr_ptr.
- Pop when out_vld && out_rdy.
- in_rdy = (count < DEPTH), computed from registered state only. There is no combinational dependence on out_rdy.
  - When full, a same-cycle pop does not enable a push; in_rdy rises the cycle after the pop.
- out_vld = (count != 0) && !stall.
- out_data/out_ctrl = mem[rd_ptr] whenever count != 0; otherwise out_data = 0 and out_ctrl = 0.
- While stall=1: no pop. Pushes continue while in_rdy=1.
- Simultaneous push and pop (non-full, non-empty): count unchanged and both pointers advance.
- Push into an empty FIFO: the word appears at the output the next cycle; no same-cycle bypass.
- Pointers run 0..DEPTH-1 and wrap to 0 after DEPTH-1.
- count += push − pop, saturating arithmetic is not needed because it is guaranteed by in_rdy.
- flush=1: pointers and count go to 0 the next edge. Any push or pop in that cycle is discarded. overflow_err is kept.
- reset: highest priority. Clears pointers, count, overflow_err and output registers. Memory contents are don't-care.
- Control states (derived from count): EMPTY (0), PARTIAL, FULL (DEPTH). Transitions occur only via push, pop, flush or reset.

## Timing
- Reset values: in_rdy=1 (the cycle after reset deasserts it reflects count=0), out_vld=0, out_data=0, out_ctrl=0, count=0, overflow_err=0.
- During reset, in_rdy=0.
- Latency: push at edge N gives out_vld=1 in cycle N+1 (if not stalled).
- Throughput: one word per cycle sustained when out_rdy=1, for DEPTH≥2.
- Handshake:
  - out_data/out_ctrl are stable while out_vld=1 && out_rdy=0.
  - out_vld is never withdrawn without a pop, except by stall, flush or reset.
- flush and stall are sampled at clk; their effects are visible in the next cycle.

## Structure
- global_buffer_param holds CGRA_DATA_WIDTH. A packed typedef strm_word_t {logic ctrl; logic [CGRA_DATA_WIDTH-1:0] data;} is added there.
- One natural sub-module: glb_strm_fifo_mem, a DEPTH×(DATA_WIDTH+1) register array with a single write port and an asynchronous read port.
- The pointer and count logic stays in the top module.

## Test plan
- Reset then push 0x0001..0x0004 with out_rdy=0, DEPTH=4. Expect: count=4, in_rdy=0 next cycle; then out_rdy=1 pops 0x0001..0x0004 in order, one per cycle.
- Streaming: in_vld=1 and out_rdy=1 for 100 cycles with incrementing data. Expect: output matches input with 1-cycle latency, count stays 1, no bubbles.
- Wrap and non-power-of-two: DEPTH=3, random vld/rdy for 1000 cycles. Expect: scoreboard order preserved, count ≤ 3, overflow_err=0.
- Stall: 2 entries held, stall=1 with out_rdy=1. Expect: out_vld=0 and no pops; pushes still accepted up to FULL; after stall=0, entries drain in order.
- Flush mid-stream: 3 entries, flush=1 together with push 0xBEEF. Expect: next cycle count=0, out_vld=0, in_rdy=1, and 0xBEEF never appears at the output.
- Full with simultaneous pop: count=4, out_rdy=1, in_vld=1. Expect: the pop completes, no push that cycle, in_rdy=1 the next cycle, and count goes 4→3→4 on the following push.
